// File: rtl/idli_pctl_m.sv
// ----------------------------------------------------------------------------
// idli_pctl_m -- predicate register file controller
//
// Owns the PRF read (P) and write (Q) ports. When idle, execute predicate
// reads and writes pass straight through. A level request starts a short
// bit-serial sequence over P0..P(NUM_PREGS-1). P3 is hardwired in the PRF and
// is never sequenced.
//   SAVE : reads the registers out, one per cycle, P0 first.
//   RSTR : writes the registers in, one per cycle, P0 first.
// Execute is stalled (o_pctl_ex_rdy=0) for the whole sequence.
//
// Ports
//   i_pctl_gck / i_pctl_rst_n     clock, async active-low reset
//   i_pctl_ex_rd_preg             execute read select
//   o_pctl_ex_rd_data             execute read data (0 while busy)
//   i_pctl_ex_wr_vld/_preg/_data  execute write request
//   o_pctl_ex_rdy                 execute access honoured this cycle
//   i_pctl_save_req               level request, serialise registers out
//   o_pctl_save_vld/_data/_done   save bit stream, done on the last bit
//   i_pctl_rstr_req               level request, serialise registers in
//   i_pctl_rstr_data              restore bit, consumed when o_pctl_rstr_rdy=1
//   o_pctl_rstr_rdy               restore bit consumed this cycle
//   o_pctl_prf_p / i_pctl_prf_p_data               PRF read port
//   o_pctl_prf_q / _q_wr_en / _q_data              PRF write port
// ----------------------------------------------------------------------------
module idli_pctl_m #(
  parameter int NUM_PREGS = 3,
  parameter int CNT_W     = 2
) (
  input  logic       i_pctl_gck,
  input  logic       i_pctl_rst_n,
  input  logic [1:0] i_pctl_ex_rd_preg,
  output logic       o_pctl_ex_rd_data,
  input  logic       i_pctl_ex_wr_vld,
  input  logic [1:0] i_pctl_ex_wr_preg,
  input  logic       i_pctl_ex_wr_data,
  output logic       o_pctl_ex_rdy,
  input  logic       i_pctl_save_req,
  output logic       o_pctl_save_vld,
  output logic       o_pctl_save_data,
  output logic       o_pctl_save_done,
  input  logic       i_pctl_rstr_req,
  input  logic       i_pctl_rstr_data,
  output logic       o_pctl_rstr_rdy,
  output logic [1:0] o_pctl_prf_p,
  input  logic       i_pctl_prf_p_data,
  output logic [1:0] o_pctl_prf_q,
  output logic       o_pctl_prf_q_wr_en,
  output logic       o_pctl_prf_q_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_RSTR = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  // Last register of the sequence; the busy state returns to IDLE after it.
  assign w_last = (r_cnt == CNT_W'(NUM_PREGS - 1));

  // --------------------------------------------------------------------------
  // State / counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pctl_gck or negedge i_pctl_rst_n) begin
    if (!i_pctl_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state. SAVE has priority over RSTR when both are requested; the
  // losing request is a level and is served once the sequencer is idle again.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (i_pctl_save_req)      w_state_nxt = ST_SAVE;
        else if (i_pctl_rstr_req) w_state_nxt = ST_RSTR;
      end
      ST_SAVE, ST_RSTR: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. All combinational from state so that an asynchronous reset
  // mid-sequence drops the sequencer write in the same cycle and the Q port
  // falls back to the execute request.
  // --------------------------------------------------------------------------
  always_comb begin
    o_pctl_ex_rdy      = 1'b0;
    o_pctl_ex_rd_data  = 1'b0;
    o_pctl_save_vld    = 1'b0;
    o_pctl_save_data   = 1'b0;
    o_pctl_save_done   = 1'b0;
    o_pctl_rstr_rdy    = 1'b0;
    o_pctl_prf_p       = i_pctl_ex_rd_preg;
    o_pctl_prf_q       = i_pctl_ex_wr_preg;
    o_pctl_prf_q_wr_en = 1'b0;
    o_pctl_prf_q_data  = i_pctl_ex_wr_data;
    case (r_state)
      ST_IDLE: begin
        // Pass-through. A write to P3 is forwarded untouched; the PRF drops it.
        o_pctl_ex_rdy      = 1'b1;
        o_pctl_ex_rd_data  = i_pctl_prf_p_data;
        o_pctl_prf_q_wr_en = i_pctl_ex_wr_vld;
      end
      ST_SAVE: begin
        o_pctl_prf_p     = 2'(r_cnt);
        o_pctl_save_vld  = 1'b1;
        o_pctl_save_data = i_pctl_prf_p_data;
        o_pctl_save_done = w_last;
      end
      ST_RSTR: begin
        o_pctl_prf_q       = 2'(r_cnt);
        o_pctl_prf_q_wr_en = 1'b1;
        o_pctl_prf_q_data  = i_pctl_rstr_data;
        o_pctl_rstr_rdy    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idli_pctl_m.sv
module tb_idli_pctl_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ex_rd_preg;
  logic       ex_rd_data;
  logic       ex_wr_vld;
  logic [1:0] ex_wr_preg;
  logic       ex_wr_data;
  logic       ex_rdy;
  logic       save_req, save_vld, save_data, save_done;
  logic       rstr_req, rstr_data, rstr_rdy;
  logic [1:0] prf_p, prf_q;
  logic       prf_p_data, q_wr_en, q_data;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and per-cycle check strobes
  logic [1:0] save_q[$];   // {data, done}
  logic [2:0] rstr_q[$];   // {q index, data}
  logic       rd_q[$];     // expected ex_rd_data
  logic       rdy_q[$];    // expected ex_rdy
  logic       rd_chk  = 1'b0;
  logic       rdy_chk = 1'b0;

  always #5 clk = ~clk;

  idli_pctl_m #(.NUM_PREGS(3), .CNT_W(2)) dut (
    .i_pctl_gck        (clk),
    .i_pctl_rst_n      (rst_n),
    .i_pctl_ex_rd_preg (ex_rd_preg),
    .o_pctl_ex_rd_data (ex_rd_data),
    .i_pctl_ex_wr_vld  (ex_wr_vld),
    .i_pctl_ex_wr_preg (ex_wr_preg),
    .i_pctl_ex_wr_data (ex_wr_data),
    .o_pctl_ex_rdy     (ex_rdy),
    .i_pctl_save_req   (save_req),
    .o_pctl_save_vld   (save_vld),
    .o_pctl_save_data  (save_data),
    .o_pctl_save_done  (save_done),
    .i_pctl_rstr_req   (rstr_req),
    .i_pctl_rstr_data  (rstr_data),
    .o_pctl_rstr_rdy   (rstr_rdy),
    .o_pctl_prf_p      (prf_p),
    .i_pctl_prf_p_data (prf_p_data),
    .o_pctl_prf_q      (prf_q),
    .o_pctl_prf_q_wr_en(q_wr_en),
    .o_pctl_prf_q_data (q_data)
  );

  // PRF model: P0..P2 storage, P3 reads 1, writes to P3 discarded, not reset.
  logic [2:0] prf = 3'b000;
  always_comb begin
    case (prf_p)
      2'd0:    prf_p_data = prf[0];
      2'd1:    prf_p_data = prf[1];
      2'd2:    prf_p_data = prf[2];
      default: prf_p_data = 1'b1;
    endcase
  end
  always @(posedge clk) begin
    if (q_wr_en) begin
      case (prf_q)
        2'd0: prf[0] <= q_data;
        2'd1: prf[1] <= q_data;
        2'd2: prf[2] <= q_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (save_vld) begin
        chk("save_no_q_wr", {3'b0, q_wr_en}, 4'd0);
        if (save_q.size() == 0) chk("save_unexpected", 4'd1, 4'd0);
        else chk("save_bit", {2'b0, save_data, save_done}, {2'b0, save_q.pop_front()});
      end
      if (rstr_rdy) begin
        if (rstr_q.size() == 0) chk("rstr_unexpected", 4'd1, 4'd0);
        else chk("rstr_wr", {q_wr_en, prf_q, q_data}, {1'b1, rstr_q.pop_front()});
      end
      if (rd_chk) begin
        if (rd_q.size() == 0) chk("rd_q_empty", 4'd1, 4'd0);
        else chk("ex_rd_data", {3'b0, ex_rd_data}, {3'b0, rd_q.pop_front()});
      end
      if (rdy_chk) begin
        if (rdy_q.size() == 0) chk("rdy_q_empty", 4'd1, 4'd0);
        else begin
          logic e;
          e = rdy_q.pop_front();
          chk("ex_rdy", {3'b0, ex_rdy}, {3'b0, e});
          if (!e) chk("busy_rd_zero", {3'b0, ex_rd_data}, 4'd0);
        end
      end
    end
  end

  // One clock cycle with the current inputs; expects ex_rdy=erdy.
  task automatic step(input logic erdy);
    rdy_q.push_back(erdy);
    rdy_chk = 1'b1;
    @(posedge clk); #1;
    rdy_chk = 1'b0;
  endtask

  task automatic ex_wr(input logic [1:0] r, input logic d);
    ex_wr_vld = 1'b1; ex_wr_preg = r; ex_wr_data = d;
    step(1'b1);
    ex_wr_vld = 1'b0;
  endtask

  task automatic ex_rd(input logic [1:0] r, input logic exp);
    ex_rd_preg = r;
    rd_q.push_back(exp);
    rd_chk = 1'b1;
    step(1'b1);
    rd_chk = 1'b0;
    ex_rd_preg = 2'd3;
  endtask

  task automatic rd3(input logic [2:0] exp);
    ex_rd(2'd0, exp[0]);
    ex_rd(2'd1, exp[1]);
    ex_rd(2'd2, exp[2]);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_rd_preg = 2'd3; ex_wr_vld = 1'b0; ex_wr_preg = 2'd0;
    ex_wr_data = 1'b0; save_req = 1'b0; rstr_req = 1'b0; rstr_data = 1'b0;
    #2;
    chk("rst_ex_rdy",   {3'b0, ex_rdy},   4'd1);
    chk("rst_save_vld", {3'b0, save_vld}, 4'd0);
    chk("rst_rstr_rdy", {3'b0, rstr_rdy}, 4'd0);
    chk("rst_q_wr_en",  {3'b0, q_wr_en},  4'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1. pass-through write/read, P3 reads 1
    ex_wr(2'd1, 1'b1);
    ex_rd(2'd1, 1'b1);
    ex_rd(2'd3, 1'b1);

    // 2. P0..P2 = 1,0,1 then save
    ex_wr(2'd0, 1'b1);
    ex_wr(2'd1, 1'b0);
    ex_wr(2'd2, 1'b1);
    save_req = 1'b1;
    step(1'b1);
    save_req = 1'b0;
    save_q.push_back(2'b10); save_q.push_back(2'b00); save_q.push_back(2'b11);
    repeat (3) step(1'b0);
    step(1'b1);

    // 3. restore 0,1,1
    rstr_req = 1'b1;
    step(1'b1);
    rstr_req = 1'b0;
    rstr_data = 1'b0; rstr_q.push_back({2'd0, 1'b0}); step(1'b0);
    rstr_data = 1'b1; rstr_q.push_back({2'd1, 1'b1}); step(1'b0);
    rstr_data = 1'b1; rstr_q.push_back({2'd2, 1'b1}); step(1'b0);
    rd3(3'b110);

    // 4. simultaneous requests: SAVE then RSTR; held ex write to P2 lands
    //    only in the idle gap, so the save still reads P2=1
    save_req = 1'b1; rstr_req = 1'b1;
    step(1'b1);
    save_req = 1'b0;
    ex_wr_vld = 1'b1; ex_wr_preg = 2'd2; ex_wr_data = 1'b0;
    save_q.push_back(2'b00); save_q.push_back(2'b10); save_q.push_back(2'b11);
    repeat (3) step(1'b0);
    step(1'b1);
    ex_wr_vld = 1'b0; rstr_req = 1'b0;
    rstr_data = 1'b1; rstr_q.push_back({2'd0, 1'b1}); step(1'b0);
    rstr_data = 1'b0; rstr_q.push_back({2'd1, 1'b0}); step(1'b0);
    rstr_data = 1'b1; rstr_q.push_back({2'd2, 1'b1}); step(1'b0);
    rd3(3'b101);

    // 5. ex write P2<=0 in the accepting cycle is visible to the save
    save_req = 1'b1; ex_wr_vld = 1'b1; ex_wr_preg = 2'd2; ex_wr_data = 1'b0;
    step(1'b1);
    save_req = 1'b0; ex_wr_vld = 1'b0;
    save_q.push_back(2'b10); save_q.push_back(2'b00); save_q.push_back(2'b01);
    repeat (3) step(1'b0);
    step(1'b1);

    // 6. reset during the P2 restore cycle: no write, P2 keeps 0
    rstr_req = 1'b1;
    step(1'b1);
    rstr_req = 1'b0;
    rstr_data = 1'b0; rstr_q.push_back({2'd0, 1'b0}); step(1'b0);
    rstr_data = 1'b1; rstr_q.push_back({2'd1, 1'b1}); step(1'b0);
    rstr_data = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_q_wr_en", {3'b0, q_wr_en},  4'd0);
    chk("midrst_rstr_rdy", {3'b0, rstr_rdy}, 4'd0);
    chk("midrst_ex_rdy",  {3'b0, ex_rdy},   4'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1);
    rd3(3'b010);

    chk("save_q_left", 4'(save_q.size()), 4'd0);
    chk("rstr_q_left", 4'(rstr_q.size()), 4'd0);
    chk("rd_q_left",   4'(rd_q.size()),   4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
